branch_hazard_unit: RTL and testbench

BRANCH_HAZARD_UNIT -- requirements
Module: branch_hazard_unit

---
 rtl/branch_hazard_unit.sv | 126 ++++++++++++
 tb/tb_branch_hazard_unit.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/branch_hazard_unit.sv
// IF/ID pipeline register with load-use stall detection and BEQ resolution in decode.
// Drives hold (IFIDwrite/pc_hazard) and taken-branch (equal/imm) requests to the program counter.
module branch_hazard_unit #(
    parameter int unsigned N = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] pc_in,
    input  logic [N-1:0] instr_in,
    input  logic [N-1:0] rs_data,
    input  logic [N-1:0] rt_data,
    input  logic         idex_memread,
    input  logic [4:0]   idex_rt,
    output logic [N-1:0] ifid_pc,
    output logic [N-1:0] ifid_instr,
    output logic         ifid_valid,
    output logic [N-1:0] imm,
    output logic         equal,
    output logic         IFIDwrite,
    output logic [N-1:0] pc_hazard,
    output logic [15:0]  stall_cnt,
    output logic [15:0]  flush_cnt
);

    localparam logic [1:0] StRun   = 2'd0;
    localparam logic [1:0] StStall = 2'd1;
    localparam logic [1:0] StFlush = 2'd2;

    localparam logic [5:0] OpBeq = 6'b000100;

    logic [1:0]   state_q, state_d;
    logic [N-1:0] ifid_pc_q, ifid_pc_d;
    logic [N-1:0] ifid_instr_q, ifid_instr_d;
    logic         ifid_valid_q, ifid_valid_d;
    logic [15:0]  stall_cnt_q, stall_cnt_d;
    logic [15:0]  flush_cnt_q, flush_cnt_d;

    logic [5:0] opcode;
    logic [4:0] rs_field;
    logic [4:0] rt_field;
    logic       hz;
    logic       bt;
    logic       in_run;

    always_comb begin
        opcode   = ifid_instr_q[31:26];
        rs_field = ifid_instr_q[25:21];
        rt_field = ifid_instr_q[20:16];

        hz = ifid_valid_q && idex_memread && (idex_rt != 5'd0) &&
             ((idex_rt == rs_field) || (idex_rt == rt_field));
        // A pending load-use hazard means the branch operands are stale.
        bt = ifid_valid_q && (opcode == OpBeq) && (rs_data == rt_data) && !hz;

        in_run    = (state_q == StRun);
        IFIDwrite = hz && in_run;
        equal     = bt && in_run;
        pc_hazard = pc_in;
    end

    always_comb begin
        state_d = StRun;
        case (state_q)
            StRun: begin
                if (hz) begin
                    state_d = StStall;
                end else if (bt) begin
                    state_d = StFlush;
                end
            end
            default: state_d = StRun;
        endcase
    end

    always_comb begin
        ifid_pc_d    = pc_in;
        ifid_instr_d = instr_in;
        ifid_valid_d = 1'b1;
        if (IFIDwrite) begin
            ifid_pc_d    = ifid_pc_q;
            ifid_instr_d = ifid_instr_q;
            ifid_valid_d = ifid_valid_q;
        end else if (equal) begin
            // Squash the wrong-path fetch that arrives alongside the taken branch.
            ifid_instr_d = '0;
            ifid_valid_d = 1'b0;
        end
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (IFIDwrite && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end
        if (equal && (flush_cnt_q != 16'hFFFF)) begin
            flush_cnt_d = flush_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= StRun;
            ifid_pc_q    <= '0;
            ifid_instr_q <= '0;
            ifid_valid_q <= 1'b0;
            stall_cnt_q  <= '0;
            flush_cnt_q  <= '0;
        end else begin
            state_q      <= state_d;
            ifid_pc_q    <= ifid_pc_d;
            ifid_instr_q <= ifid_instr_d;
            ifid_valid_q <= ifid_valid_d;
            stall_cnt_q  <= stall_cnt_d;
            flush_cnt_q  <= flush_cnt_d;
        end
    end

    assign ifid_pc    = ifid_pc_q;
    assign ifid_instr = ifid_instr_q;
    assign ifid_valid = ifid_valid_q;
    assign imm        = {{(N-16){ifid_instr_q[15]}}, ifid_instr_q[15:0]};
    assign stall_cnt  = stall_cnt_q;
    assign flush_cnt  = flush_cnt_q;

endmodule

// File: tb/tb_branch_hazard_unit.sv
// Directed bench for branch_hazard_unit: per-cycle comparison against a pipeline-level model,
// plus hand-computed literal expectations at each scenario.
module tb_branch_hazard_unit;

    logic        clk;
    logic        rst;
    logic [31:0] pc_in, instr_in, rs_data, rt_data;
    logic        idex_memread;
    logic [4:0]  idex_rt;
    logic [31:0] ifid_pc, ifid_instr, imm, pc_hazard;
    logic        ifid_valid, equal, IFIDwrite;
    logic [15:0] stall_cnt, flush_cnt;

    int n_checks = 0;
    int n_err    = 0;

    branch_hazard_unit #(.N(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .pc_in        (pc_in),
        .instr_in     (instr_in),
        .rs_data      (rs_data),
        .rt_data      (rt_data),
        .idex_memread (idex_memread),
        .idex_rt      (idex_rt),
        .ifid_pc      (ifid_pc),
        .ifid_instr   (ifid_instr),
        .ifid_valid   (ifid_valid),
        .imm          (imm),
        .equal        (equal),
        .IFIDwrite    (IFIDwrite),
        .pc_hazard    (pc_hazard),
        .stall_cnt    (stall_cnt),
        .flush_cnt    (flush_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] mk(input logic [5:0] op, input logic [4:0] rs,
                                       input logic [4:0] rt, input logic [15:0] off);
        return {op, rs, rt, off};
    endfunction

    // Model: contents of the decode slot, whether this cycle is a bubble (the cycle after a
    // hold or a taken branch, when no new request may be raised), and the event counts.
    logic [31:0] m_pc, m_instr;
    logic        m_valid, m_bubble;
    logic [15:0] m_stall, m_flush;
    logic [31:0] nx_pc, nx_instr;
    logic        nx_valid, nx_bubble;
    logic [15:0] nx_stall, nx_flush;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_pc = 0; m_instr = 0; m_valid = 0; m_bubble = 0; m_stall = 0; m_flush = 0;
        end else begin
            m_pc = nx_pc; m_instr = nx_instr; m_valid = nx_valid;
            m_bubble = nx_bubble; m_stall = nx_stall; m_flush = nx_flush;
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            logic load_use, taken, e_hold, e_take;
            logic [4:0] rs, rt;
            rs = m_instr[25:21];
            rt = m_instr[20:16];
            load_use = m_valid && idex_memread && idex_rt != 0 && (idex_rt == rs || idex_rt == rt);
            taken    = m_valid && m_instr[31:26] == 6'd4 && rs_data == rt_data && !load_use;
            e_hold   = load_use && !m_bubble;
            e_take   = taken && !m_bubble;
            check("m_IFIDwrite", {31'd0, IFIDwrite}, {31'd0, e_hold});
            check("m_equal", {31'd0, equal}, {31'd0, e_take});
            check("m_exclusive", {31'd0, IFIDwrite & equal}, 32'd0);
            check("m_imm", imm, {{16{m_instr[15]}}, m_instr[15:0]});
            check("m_pc_hazard", pc_hazard, pc_in);
            check("m_ifid_pc", ifid_pc, m_pc);
            check("m_ifid_instr", ifid_instr, m_instr);
            check("m_ifid_valid", {31'd0, ifid_valid}, {31'd0, m_valid});
            check("m_stall_cnt", {16'd0, stall_cnt}, {16'd0, m_stall});
            check("m_flush_cnt", {16'd0, flush_cnt}, {16'd0, m_flush});
            nx_stall = m_stall;
            nx_flush = m_flush;
            if (e_hold) begin
                nx_pc = m_pc; nx_instr = m_instr; nx_valid = m_valid; nx_bubble = 1;
                if (m_stall != 16'hFFFF) nx_stall = m_stall + 1;
            end else if (e_take) begin
                nx_pc = pc_in; nx_instr = 0; nx_valid = 0; nx_bubble = 1;
                if (m_flush != 16'hFFFF) nx_flush = m_flush + 1;
            end else begin
                nx_pc = pc_in; nx_instr = instr_in; nx_valid = 1; nx_bubble = 0;
            end
        end
    end

    task automatic drive(input logic [31:0] pc, input logic [31:0] ins, input logic [31:0] rsd,
                         input logic [31:0] rtd, input logic mr, input logic [4:0] irt);
        pc_in = pc; instr_in = ins; rs_data = rsd; rt_data = rtd;
        idex_memread = mr; idex_rt = irt;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_ifid_pc"}, ifid_pc, 32'd0);
        check({tag, "_ifid_instr"}, ifid_instr, 32'd0);
        check({tag, "_ifid_valid"}, {31'd0, ifid_valid}, 32'd0);
        check({tag, "_imm"}, imm, 32'd0);
        check({tag, "_IFIDwrite"}, {31'd0, IFIDwrite}, 32'd0);
        check({tag, "_equal"}, {31'd0, equal}, 32'd0);
        check({tag, "_stall_cnt"}, {16'd0, stall_cnt}, 32'd0);
        check({tag, "_flush_cnt"}, {16'd0, flush_cnt}, 32'd0);
    endtask

    logic [31:0] beq;

    initial begin
        rst = 1'b1;
        drive(0, 0, 0, 0, 0, 0);
        check_all_zero("reset");
        tick(); tick();
        rst = 1'b0;

        for (int i = 0; i < 3; i++) begin
            drive(i, mk(0, 1, 2, 16'(i)), 0, 0, 0, 0);
            tick();
            check("seq_ifid_pc", ifid_pc, i);
            check("seq_ifid_valid", {31'd0, ifid_valid}, 32'd1);
        end

        // Load-use on rs=3.
        drive(10, mk(0, 3, 4, 0), 0, 0, 0, 0);
        tick();
        drive(11, mk(0, 5, 6, 0), 0, 0, 1, 3);
        check("lu_IFIDwrite", {31'd0, IFIDwrite}, 32'd1);
        check("lu_pc_hazard", pc_hazard, 32'd11);
        tick();
        check("lu_held_pc", ifid_pc, 32'd10);
        check("lu_held_instr", ifid_instr, mk(0, 3, 4, 0));
        check("lu_stall_cnt", {16'd0, stall_cnt}, 32'd1);
        check("lu_next_IFIDwrite", {31'd0, IFIDwrite}, 32'd0);
        drive(11, mk(0, 5, 6, 0), 0, 0, 0, 0);
        tick();
        check("lu_reload_pc", ifid_pc, 32'd11);

        // Register zero never hazards.
        drive(20, mk(0, 0, 5, 0), 0, 0, 0, 0);
        tick();
        drive(21, mk(0, 1, 1, 0), 0, 0, 1, 0);
        check("r0_IFIDwrite", {31'd0, IFIDwrite}, 32'd0);
        tick();
        check("r0_ifid_pc", ifid_pc, 32'd21);

        // Taken BEQ with negative offset.
        drive(8, mk(4, 1, 2, 16'hFFFC), 0, 1, 0, 0);
        tick();
        drive(9, mk(0, 1, 1, 0), 5, 5, 0, 0);
        check("bt_equal", {31'd0, equal}, 32'd1);
        check("bt_imm", imm, 32'hFFFF_FFFC);
        check("bt_base", ifid_pc, 32'd8);
        tick();
        check("bt_flush_valid", {31'd0, ifid_valid}, 32'd0);
        check("bt_flush_instr", ifid_instr, 32'd0);
        check("bt_flush_cnt", {16'd0, flush_cnt}, 32'd1);
        check("bt_flush_equal", {31'd0, equal}, 32'd0);
        drive(12, mk(0, 2, 2, 7), 5, 5, 0, 0);
        tick();
        check("bt_after_valid", {31'd0, ifid_valid}, 32'd1);
        check("bt_after_pc", ifid_pc, 32'd12);

        // Not-taken BEQ.
        drive(14, mk(4, 1, 2, 3), 0, 0, 0, 0);
        tick();
        drive(15, mk(0, 1, 1, 0), 5, 6, 0, 0);
        check("nt_equal", {31'd0, equal}, 32'd0);
        tick();
        check("nt_valid", {31'd0, ifid_valid}, 32'd1);
        check("nt_flush_cnt", {16'd0, flush_cnt}, 32'd1);

        // Hazard beats branch, branch resolves on the next RUN cycle.
        beq = mk(4, 3, 7, 4);
        drive(30, beq, 0, 0, 0, 0);
        tick();
        drive(31, mk(0, 1, 1, 0), 5, 5, 1, 7);
        check("pri_IFIDwrite", {31'd0, IFIDwrite}, 32'd1);
        check("pri_equal", {31'd0, equal}, 32'd0);
        tick();
        check("pri_stall_equal", {31'd0, equal}, 32'd0);
        drive(30, beq, 5, 5, 0, 0);
        tick();
        check("pri_run_equal", {31'd0, equal}, 32'd1);
        check("pri_run_IFIDwrite", {31'd0, IFIDwrite}, 32'd0);
        drive(31, mk(0, 1, 1, 0), 0, 0, 0, 0);
        tick();
        check("pri_flush_cnt", {16'd0, flush_cnt}, 32'd2);
        drive(32, mk(0, 1, 1, 0), 0, 0, 0, 0);
        tick();

        // Saturation: start the counter just below the top, then keep stalling.
        force dut.stall_cnt_q = 16'hFFF0;
        m_stall = 16'hFFF0;
        #1;
        release dut.stall_cnt_q;
        drive(50, mk(0, 3, 0, 0), 0, 0, 0, 0);
        tick();
        drive(51, mk(0, 3, 0, 0), 0, 0, 1, 3);
        repeat (40) tick();
        check("sat_stall_cnt", {16'd0, stall_cnt}, 32'h0000_FFFF);
        drive(52, mk(0, 1, 1, 0), 0, 0, 0, 0);
        tick();

        // Reset asserted between edges while in FLUSH.
        drive(40, mk(4, 1, 2, 8), 0, 1, 0, 0);
        tick();
        drive(41, mk(0, 1, 1, 0), 9, 9, 0, 0);
        check("rst_pre_equal", {31'd0, equal}, 32'd1);
        tick();
        #2;
        rst = 1'b1;
        #1;
        check_all_zero("rst_mid");
        tick();
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive(i, mk(0, 1, 2, 0), 0, 0, 0, 0);
            tick();
            check("rst_seq_pc", ifid_pc, i);
            check("rst_seq_valid", {31'd0, ifid_valid}, 32'd1);
        end
        check("rst_stall_cnt", {16'd0, stall_cnt}, 32'd0);
        check("rst_flush_cnt", {16'd0, flush_cnt}, 32'd0);
        tick();

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
